// File: rtl/pwm_meas.sv
// -----------------------------------------------------------------------------
// pwm_meas -- measures period, high time, duty cycle and frequency of an
// asynchronous PWM input.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   pwm_in      asynchronous PWM input
//   period_cnt  last measured period in clk cycles
//   high_cnt    last measured high time in clk cycles
//   pwm_duty    duty cycle in integer percent (0..100)
//   pwm_rate    input frequency in Hz, saturated to 2^21-1
//   meas_valid  one-cycle strobe when the four result outputs update
//   no_signal   high after a timeout until the next real measurement
//   dbg_state   current FSM state (IDLE=0, MEAS=1, DIV_DUTY=2, DIV_RATE=3)
//
// Output handshake: meas_valid is a pure strobe with no ready/backpressure.
// period_cnt, high_cnt, pwm_duty, pwm_rate and no_signal change only in the
// cycle meas_valid is high and hold their value at all other times.
// -----------------------------------------------------------------------------
module pwm_meas #(
    parameter int unsigned CLK_FRE = 50_000_000,
    parameter int unsigned CNT_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [9:0]       pwm_duty,
    output logic [20:0]      pwm_rate,
    output logic             meas_valid,
    output logic             no_signal,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEAS     = 2'd1,
        S_DIV_DUTY = 2'd2,
        S_DIV_RATE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_TO    = CNT_MAX - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [31:0]      CLK_FRE_W = 32'(CLK_FRE);
    localparam logic [31:0]      RATE_MAX  = 32'h001F_FFFF;
    localparam logic [31:0]      DUTY_MAX  = 32'd100;
    localparam logic [5:0]       LAST_ITER = 6'd31;
    localparam logic [5:0]       DIV_STEPS = 6'd32;

    state_t state;

    // ---------------- synchronizer and edge detect ----------------
    // sync_q[0..1] form the synchronizer, sync_q[2] is the delay flop.
    logic [2:0] sync_q;
    logic       rise;
    logic       fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pwm_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

    // ---------------- period / high counter ----------------
    // cnt is 1 in the cycle after a rise detect, so in the next rise-detect
    // cycle it equals the period; a fall captures the high time the same way.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_acc;
    logic             timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            high_acc <= '0;
        end else if (rise) begin
            cnt      <= CNT_ONE;
            high_acc <= '0;
        end else begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end
            if (fall) begin
                high_acc <= cnt;
            end
        end
    end

    // Fires once: the counter then sits saturated at CNT_MAX.
    assign timeout = !rise && (cnt == CNT_TO);

    // ---------------- shared restoring divider step ----------------
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [5:0]  div_cnt;
    logic [32:0] rem_sh;
    logic [32:0] rem_sub;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;

    always_comb begin
        rem_sh  = {rem_q, quo_q[31]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        // Borrow out of bit 32 means the shifted remainder was below the divisor.
        if (!rem_sub[32]) begin
            rem_nx = rem_sub[31:0];
            quo_nx = {quo_q[30:0], 1'b1};
        end else begin
            rem_nx = rem_sh[31:0];
            quo_nx = {quo_q[30:0], 1'b0};
        end
    end

    // ---------------- control FSM ----------------
    logic [CNT_W-1:0] per_snap;
    logic [CNT_W-1:0] high_snap;
    logic [9:0]       duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            per_snap   <= '0;
            high_snap  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            div_cnt    <= '0;
            duty_q     <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            pwm_duty   <= '0;
            pwm_rate   <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                S_IDLE, S_MEAS: begin
                    if (rise) begin
                        if (state == S_MEAS) begin
                            // Close the period and start the duty division
                            // straight away: dividend high*100, divisor period.
                            per_snap  <= cnt;
                            high_snap <= high_acc;
                            rem_q     <= '0;
                            quo_q     <= 32'(high_acc) * 32'd100;
                            dvs_q     <= 32'(cnt);
                            div_cnt   <= '0;
                            state     <= S_DIV_DUTY;
                        end else begin
                            // First edge only opens a period.
                            state <= S_MEAS;
                        end
                    end else if (timeout) begin
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        pwm_rate   <= '0;
                        pwm_duty   <= sync_q[1] ? 10'd100 : 10'd0;
                        no_signal  <= 1'b1;
                        meas_valid <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_DIV_DUTY: begin
                    if (div_cnt == LAST_ITER) begin
                        // Last duty step lands directly in duty_q while the
                        // rate division is loaded; the divisor is unchanged.
                        duty_q  <= (quo_nx > DUTY_MAX) ? 10'd100 : quo_nx[9:0];
                        rem_q   <= '0;
                        quo_q   <= CLK_FRE_W;
                        div_cnt <= '0;
                        state   <= S_DIV_RATE;
                    end else begin
                        rem_q   <= rem_nx;
                        quo_q   <= quo_nx;
                        div_cnt <= div_cnt + 6'd1;
                    end
                end
                S_DIV_RATE: begin
                    if (div_cnt != DIV_STEPS) begin
                        rem_q   <= rem_nx;
                        quo_q   <= quo_nx;
                        div_cnt <= div_cnt + 6'd1;
                    end else begin
                        // Commit cycle: all results update together.
                        period_cnt <= per_snap;
                        high_cnt   <= high_snap;
                        pwm_duty   <= duty_q;
                        pwm_rate   <= (quo_q > RATE_MAX) ? 21'h1F_FFFF : quo_q[20:0];
                        no_signal  <= 1'b0;
                        meas_valid <= 1'b1;
                        state      <= S_MEAS;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
